// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   MEM/WB pipeline boundary. Captures the memory-stage result and drives the
//   register-file write port and forwarding value. It owns the data-memory read
//   response handshake: a load without a same-cycle response stalls upstream
//   until the response arrives. A watchdog abandons a load after MAX_WAIT wait
//   cycles and raises a sticky timeout flag.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   valid_i         memory stage holds a valid instruction
//   regwrite_i      instruction writes rd
//   memread_i       instruction is a load
//   funct3_i        load type (RISC-V funct3)
//   rd_i            destination register
//   wb_data_i       non-load write-back value
//   data_addr_i     load address (bits [1:0] select byte/half lane)
//   data_rdata_i    data-memory read data
//   data_rvalid_i   read data valid this cycle
//   regwrite_o      register-file write enable
//   rd_o            register-file write address
//   rd_data_o       register-file write data / forwarding value
//   stall_o         combinational hold request to upstream stages
//   load_timeout_o  sticky: a load was abandoned (cleared only by rst)
module mem_wb_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_WAIT       = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic                      regwrite_i,
  input  logic                      memread_i,
  input  logic [2:0]                funct3_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_i,
  input  logic [DATA_WIDTH-1:0]     wb_data_i,
  input  logic [DATA_WIDTH-1:0]     data_addr_i,
  input  logic [DATA_WIDTH-1:0]     data_rdata_i,
  input  logic                      data_rvalid_i,
  output logic                      regwrite_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_o,
  output logic [DATA_WIDTH-1:0]     rd_data_o,
  output logic                      stall_o,
  output logic                      load_timeout_o
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t                  state, state_n;
  logic [7:0]              cnt, cnt_n;
  logic                    stall;
  logic                    c_upd;
  logic                    c_we;
  logic [DATA_WIDTH-1:0]   c_data;
  logic                    to_set;
  logic [DATA_WIDTH-1:0]   load_data;
  logic                    we_ok;
  logic                    unused_addr;

  assign unused_addr = ^data_addr_i[DATA_WIDTH-1:2];

  function automatic logic [31:0] extract(input logic [2:0]  f3,
                                          input logic [1:0]  a,
                                          input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'd0, b};
      3'b101:  extract = {16'd0, h};
      default: extract = d;
    endcase
  endfunction

  assign load_data = extract(funct3_i, data_addr_i[1:0], data_rdata_i);
  assign we_ok     = regwrite_i && (rd_i != '0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    c_upd   = 1'b0;
    c_we    = 1'b0;
    c_data  = wb_data_i;
    to_set  = 1'b0;
    case (state)
      IDLE: begin
        if (valid_i) begin
          if (!memread_i) begin
            c_upd = 1'b1;
            c_we  = we_ok;
          end else if (data_rvalid_i) begin
            c_upd  = 1'b1;
            c_we   = we_ok;
            c_data = load_data;
          end else begin
            stall   = 1'b1;
            state_n = WAIT;
            cnt_n   = 8'd1;
          end
        end
      end
      WAIT: begin
        if (data_rvalid_i) begin
          c_upd   = 1'b1;
          c_we    = we_ok;
          c_data  = load_data;
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt < MAX_WAIT_C) begin
          stall = 1'b1;
          cnt_n = cnt + 8'd1;
        end else begin
          // Abandon: release the stall so upstream moves past this load.
          to_set  = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Async reset forces IDLE, but the inputs may still describe a pending load;
  // gate so upstream never sees a stall while reset is held.
  assign stall_o = stall && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      regwrite_o     <= 1'b0;
      rd_o           <= '0;
      rd_data_o      <= '0;
      load_timeout_o <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      regwrite_o <= c_we;
      if (c_upd) begin
        rd_o      <= rd_i;
        rd_data_o <= c_data;
      end
      if (to_set) load_timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        regwrite_i;
  logic        memread_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic [31:0] wb_data_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_rdata_i;
  logic        data_rvalid_i;
  logic        regwrite_o;
  logic [4:0]  rd_o;
  logic [31:0] rd_data_o;
  logic        stall_o;
  logic        load_timeout_o;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(
    .DATA_WIDTH(32),
    .REG_ADDR_WIDTH(5),
    .MAX_WAIT(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .regwrite_i     (regwrite_i),
    .memread_i      (memread_i),
    .funct3_i       (funct3_i),
    .rd_i           (rd_i),
    .wb_data_i      (wb_data_i),
    .data_addr_i    (data_addr_i),
    .data_rdata_i   (data_rdata_i),
    .data_rvalid_i  (data_rvalid_i),
    .regwrite_o     (regwrite_o),
    .rd_o           (rd_o),
    .rd_data_o      (rd_data_o),
    .stall_o        (stall_o),
    .load_timeout_o (load_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] wb_data;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        rvalid;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic        exp_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic mr, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] wb, input logic [31:0] a,
                       input logic [31:0] rdata, input logic rv);
    valid_i       = v;
    regwrite_i    = rw;
    memread_i     = mr;
    funct3_i      = f3;
    rd_i          = rd;
    wb_data_i     = wb;
    data_addr_i   = a;
    data_rdata_i  = rdata;
    data_rvalid_i = rv;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // valid, rw, mr, f3, rd, wb_data, addr, rdata, rvalid | we, rd, data, stall
    vecs.push_back(vec_t'{1,1,0,3'b000,5'd5, 32'h1234_5678,32'h0,32'h0,        0, 1,5'd5, 32'h1234_5678,0});
    vecs.push_back(vec_t'{1,1,1,3'b000,5'd1, 32'h0,        32'h0,32'h80F0_7F81,1, 1,5'd1, 32'hFFFF_FF81,0});
    vecs.push_back(vec_t'{1,1,1,3'b100,5'd2, 32'h0,        32'h3,32'h80F0_7F81,1, 1,5'd2, 32'h0000_0080,0});
    vecs.push_back(vec_t'{1,1,1,3'b001,5'd3, 32'h0,        32'h2,32'h80F0_7F81,1, 1,5'd3, 32'hFFFF_80F0,0});
    vecs.push_back(vec_t'{1,1,1,3'b101,5'd4, 32'h0,        32'h0,32'h80F0_7F81,1, 1,5'd4, 32'h0000_7F81,0});
    vecs.push_back(vec_t'{1,1,1,3'b010,5'd6, 32'h0,        32'h1,32'h80F0_7F81,1, 1,5'd6, 32'h80F0_7F81,0});
    vecs.push_back(vec_t'{1,1,1,3'b010,5'd0, 32'h0,        32'h0,32'h80F0_7F81,1, 0,5'd0, 32'h80F0_7F81,0});
    vecs.push_back(vec_t'{1,1,0,3'b000,5'd8, 32'h11,       32'h0,32'hCAFE_F00D,1, 1,5'd8, 32'h0000_0011,0});
    vecs.push_back(vec_t'{0,1,1,3'b000,5'd9, 32'h99,       32'h0,32'h0,        0, 0,5'd8, 32'h0000_0011,0});
    vecs.push_back(vec_t'{1,1,1,3'b011,5'd9, 32'h0,        32'h2,32'h80F0_7F81,1, 1,5'd9, 32'h80F0_7F81,0});
    vecs.push_back(vec_t'{1,1,1,3'b000,5'd10,32'h0,        32'h1,32'h80F0_7F81,1, 1,5'd10,32'h0000_007F,0});
    vecs.push_back(vec_t'{1,1,1,3'b001,5'd11,32'h0,        32'h3,32'h80F0_7F81,1, 1,5'd11,32'hFFFF_80F0,0});
    vecs.push_back(vec_t'{1,1,1,3'b100,5'd12,32'h0,        32'h2,32'h80F0_7F81,1, 1,5'd12,32'h0000_00F0,0});
    vecs.push_back(vec_t'{1,1,1,3'b110,5'd13,32'h0,        32'h3,32'h80F0_7F81,1, 1,5'd13,32'h80F0_7F81,0});
    vecs.push_back(vec_t'{1,0,0,3'b000,5'd14,32'h55,       32'h0,32'h0,        0, 0,5'd14,32'h0000_0055,0});
    vecs.push_back(vec_t'{1,1,1,3'b000,5'd15,32'h0,        32'h2,32'h0000_0000,0, 0,5'd14,32'h0000_0055,1});
    vecs.push_back(vec_t'{1,1,1,3'b000,5'd15,32'h0,        32'h2,32'h0012_0000,1, 1,5'd15,32'h0000_0012,0});

    // Reset with a pending-load pattern on the inputs: stall must stay low.
    rst = 1'b1;
    drive(1, 1, 1, 3'b010, 5'd3, 32'h0, 32'h0, 32'h0, 0);
    #3;
    check("reset_stall", {31'd0, stall_o}, 32'd0);
    check("reset_we",    {31'd0, regwrite_o}, 32'd0);
    check("reset_rd",    {27'd0, rd_o}, 32'd0);
    check("reset_data",  rd_data_o, 32'd0);
    check("reset_to",    {31'd0, load_timeout_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 0);

    // Table vectors (includes a one-cycle wait load as the last pair).
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].regwrite, vecs[i].memread, vecs[i].funct3, vecs[i].rd,
            vecs[i].wb_data, vecs[i].addr, vecs[i].rdata, vecs[i].rvalid);
      #1;
      check($sformatf("vec%0d_stall", i), {31'd0, stall_o}, {31'd0, vecs[i].exp_stall});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_we", i),   {31'd0, regwrite_o}, {31'd0, vecs[i].exp_we});
      check($sformatf("vec%0d_rd", i),   {27'd0, rd_o}, {27'd0, vecs[i].exp_rd});
      check($sformatf("vec%0d_data", i), rd_data_o, vecs[i].exp_data);
    end

    // Wait-state load: three cycles without rvalid, then the response.
    @(negedge clk);
    drive(1, 1, 1, 3'b010, 5'd7, 32'h0, 32'h0, 32'h0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("wait%0d_stall", c), {31'd0, stall_o}, 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("wait%0d_we", c), {31'd0, regwrite_o}, 32'd0);
      @(negedge clk);
    end
    data_rdata_i  = 32'hDEAD_BEEF;
    data_rvalid_i = 1'b1;
    #1;
    check("wait_resp_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    check("wait_resp_we",   {31'd0, regwrite_o}, 32'd1);
    check("wait_resp_rd",   {27'd0, rd_o}, 32'd7);
    check("wait_resp_data", rd_data_o, 32'hDEAD_BEEF);

    // Timeout with MAX_WAIT=4: four stalled cycles, abandon on the fifth edge.
    @(negedge clk);
    drive(1, 1, 1, 3'b010, 5'd11, 32'h0, 32'h0, 32'h0, 0);
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("to%0d_stall", c), {31'd0, stall_o}, 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("to%0d_flag", c), {31'd0, load_timeout_o}, 32'd0);
      check($sformatf("to%0d_we", c),   {31'd0, regwrite_o}, 32'd0);
      @(negedge clk);
    end
    #1;
    check("to_last_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    check("to_flag", {31'd0, load_timeout_o}, 32'd1);
    check("to_we",   {31'd0, regwrite_o}, 32'd0);
    check("to_rd",   {27'd0, rd_o}, 32'd7);
    @(negedge clk);
    drive(1, 1, 0, 3'b000, 5'd12, 32'h0000_A5A5, 32'h0, 32'h0, 0);
    #1;
    check("post_to_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    check("post_to_we",   {31'd0, regwrite_o}, 32'd1);
    check("post_to_rd",   {27'd0, rd_o}, 32'd12);
    check("post_to_data", rd_data_o, 32'h0000_A5A5);
    check("post_to_flag", {31'd0, load_timeout_o}, 32'd1);

    // Reset asserted during the second cycle of a wait.
    @(negedge clk);
    drive(1, 1, 1, 3'b010, 5'd13, 32'h0, 32'h0, 32'h0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("midwait_stall_pre", {31'd0, stall_o}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_stall", {31'd0, stall_o}, 32'd0);
    check("midrst_we",    {31'd0, regwrite_o}, 32'd0);
    check("midrst_rd",    {27'd0, rd_o}, 32'd0);
    check("midrst_data",  rd_data_o, 32'd0);
    check("midrst_flag",  {31'd0, load_timeout_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 0, 3'b010, 5'd13, 32'h0, 32'h0, 32'h1357_9BDF, 1);
    #1;
    check("postrst_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    check("postrst_we",   {31'd0, regwrite_o}, 32'd0);
    check("postrst_rd",   {27'd0, rd_o}, 32'd0);
    check("postrst_data", rd_data_o, 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 0);
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
